// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system port between fetch and data.
// Alternating grant, watchdog abort, sticky flags, saturating counters.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  output logic [15:0]      i_rdata,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic [15:0]      d_rdata,
  output logic             d_done,
  output logic [15:0]      m_addr,
  output logic [15:0]      m_datain,
  output logic             m_rd,
  output logic             m_wr,
  input  logic [15:0]      m_dataout,
  input  logic             m_done,
  input  logic             m_hit,
  input  logic             m_err,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             err,
  output logic             timeout,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] req_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RESP
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nx;
  logic            last_d;
  logic [WD_W-1:0] wd;
  logic            take_i;
  logic            take_d;
  logic            in_grant;
  logic            wd_hit;

  assign in_grant = (state == GRANT_I) ||
                    (state == GRANT_D);
  assign wd_hit   = (wd == WD_LAST);
  assign busy     = (state != IDLE);
  assign i_done   = (state == RESP) && grant[0];
  assign d_done   = (state == RESP) && grant[1];

  // Next state and grant decision; only IDLE looks at requests.
  always_comb begin
    state_nx = state;
    take_i   = 1'b0;
    take_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          take_i = last_d;
          take_d = !last_d;
        end else if (i_req) begin
          take_i = 1'b1;
        end else if (d_req) begin
          take_d = 1'b1;
        end
        if (take_i) begin
          state_nx = GRANT_I;
        end else if (take_d) begin
          state_nx = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (m_done || wd_hit) begin
          state_nx = RESP;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Port capture, completion, watchdog, flags and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d   <= 1'b0;
      wd       <= '0;
      m_addr   <= '0;
      m_datain <= '0;
      m_rd     <= 1'b0;
      m_wr     <= 1'b0;
      grant    <= 2'b00;
      i_rdata  <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      hit_cnt  <= '0;
      req_cnt  <= '0;
    end else begin
      if (take_i) begin
        m_addr   <= i_addr;
        m_datain <= '0;
        m_rd     <= 1'b1;
        m_wr     <= 1'b0;
        grant    <= 2'b01;
        last_d   <= 1'b0;
        wd       <= '0;
      end
      if (take_d) begin
        m_addr   <= d_addr;
        m_datain <= d_wdata;
        m_rd     <= !d_wr;
        m_wr     <= d_wr;
        grant    <= 2'b10;
        last_d   <= 1'b1;
        wd       <= '0;
      end
      if ((take_i || take_d) && !(&req_cnt)) begin
        req_cnt <= req_cnt + 1'b1;
      end
      if (in_grant) begin
        if (m_err) begin
          err <= 1'b1;
        end
        if (m_done) begin
          m_rd <= 1'b0;
          m_wr <= 1'b0;
          if (m_hit && !(&hit_cnt)) begin
            hit_cnt <= hit_cnt + 1'b1;
          end
          if (state == GRANT_I) begin
            i_rdata <= m_dataout;
          end else if (!m_wr) begin
            d_rdata <= m_dataout;
          end
        end else if (wd_hit) begin
          m_rd    <= 1'b0;
          m_wr    <= 1'b0;
          timeout <= 1'b1;
          if (state == GRANT_I) begin
            i_rdata <= '0;
          end else begin
            d_rdata <= '0;
          end
        end else begin
          wd <= wd + 1'b1;
        end
      end
      if (state == RESP) begin
        grant <= 2'b00;
      end
    end
  end

endmodule
